// File: rtl/i2s_pkg.sv
// ----------------------------------------------------------------------------
// i2s_pkg
// Shared constants and types for the I2S master transmitter.
//   LRCLK_LEFT / LRCLK_RIGHT : word-select levels
//   SAMPLE_W_DEF, SLOT_W_DEF, BCLK_DIV_DEF : default geometry
//   frame_pos_t              : bclk position within a frame (default geometry)
//   frame_clks()             : frame length in clk cycles
// ----------------------------------------------------------------------------
package i2s_pkg;

    localparam logic LRCLK_LEFT  = 1'b0;
    localparam logic LRCLK_RIGHT = 1'b1;

    localparam int unsigned SAMPLE_W_DEF = 24;
    localparam int unsigned SLOT_W_DEF   = 32;
    localparam int unsigned BCLK_DIV_DEF = 8;

    localparam int unsigned FRAME_POS_W = $clog2(2 * SLOT_W_DEF);
    typedef logic [FRAME_POS_W-1:0] frame_pos_t;

    // Two slots of slot_w bclk periods, each bclk period being 2*bclk_div clks.
    function automatic int unsigned frame_clks(input int unsigned slot_w,
                                               input int unsigned bclk_div);
        return 4 * slot_w * bclk_div;
    endfunction

endpackage

// File: rtl/i2s_tx_bclk_gen.sv
// ----------------------------------------------------------------------------
// i2s_tx_bclk_gen
// Bit-clock divider and frame-position tracker for the I2S transmitter.
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   o_bclk         registered bit clock
//   o_lrclk        registered word select (decoded from the new position)
//   o_fall         high in the cycle whose clk edge makes bclk fall
//   o_frame_start  high in the cycle whose clk edge moves position to 0
// ----------------------------------------------------------------------------
module i2s_tx_bclk_gen
    import i2s_pkg::*;
#(
    parameter int unsigned SLOT_W   = SLOT_W_DEF,
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_bclk,
    output logic o_lrclk,
    output logic o_fall,
    output logic o_frame_start
);

    localparam int unsigned DIV_W = $clog2(BCLK_DIV);
    localparam int unsigned POS_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * SLOT_W - 1);
    localparam logic [POS_W-1:0] LR_FIRST = POS_W'(SLOT_W - 1);
    localparam logic [POS_W-1:0] LR_LAST  = POS_W'(2 * SLOT_W - 2);

    generate
        if (BCLK_DIV < 2) begin : g_bad_div
            $error("i2s_tx_bclk_gen: BCLK_DIV must be >= 2");
        end
    endgenerate

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic [POS_W-1:0] r_pos;
    logic             r_lrclk;

    logic [DIV_W-1:0] w_div_cnt_nxt;
    logic             w_bclk_nxt;
    logic [POS_W-1:0] w_pos_nxt;
    logic             w_lrclk_nxt;
    logic             w_div_wrap;
    logic             w_fall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_pos     <= POS_LAST;
            r_lrclk   <= LRCLK_LEFT;
        end else begin
            r_div_cnt <= w_div_cnt_nxt;
            r_bclk    <= w_bclk_nxt;
            r_pos     <= w_pos_nxt;
            r_lrclk   <= w_lrclk_nxt;
        end
    end

    always_comb begin
        w_div_wrap    = (r_div_cnt == DIV_LAST);
        w_fall        = w_div_wrap && r_bclk;
        w_div_cnt_nxt = w_div_wrap ? '0 : r_div_cnt + 1'b1;
        w_bclk_nxt    = w_div_wrap ? ~r_bclk : r_bclk;
        w_pos_nxt     = r_pos;
        if (w_fall) begin
            w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
        end
        // Word select switches one bclk ahead of the slot MSB.
        w_lrclk_nxt = ((w_pos_nxt >= LR_FIRST) && (w_pos_nxt <= LR_LAST)) ? LRCLK_RIGHT
                                                                           : LRCLK_LEFT;
    end

    assign o_bclk        = r_bclk;
    assign o_lrclk       = r_lrclk;
    assign o_fall        = w_fall;
    assign o_frame_start = w_fall && (r_pos == POS_LAST);

endmodule

// File: rtl/i2s_tx.sv
// ----------------------------------------------------------------------------
// i2s_tx
// I2S (Philips format) master transmitter with a one-deep sample buffer.
// Ports:
//   i_clk       system clock
//   i_reset     synchronous active-high reset
//   i_left      left sample (two's complement, SAMPLE_W bits)
//   i_right     right sample
//   i_valid     sample pair valid
//   o_ready     holding buffer empty (0 while in reset)
//   o_bclk      bit clock
//   o_lrclk     word select, 0 = left, 1 = right
//   o_sdata     serial data, MSB first, changes on bclk fall
//   o_underrun  one-cycle pulse when a frame starts with an empty buffer
// ----------------------------------------------------------------------------
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned SLOT_W   = SLOT_W_DEF,
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [SAMPLE_W-1:0] i_left,
    input  logic [SAMPLE_W-1:0] i_right,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_bclk,
    output logic                o_lrclk,
    output logic                o_sdata,
    output logic                o_underrun
);

    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned PAD_W   = SLOT_W - SAMPLE_W;

    generate
        if (SAMPLE_W > SLOT_W) begin : g_bad_width
            $error("i2s_tx: SAMPLE_W must not exceed SLOT_W");
        end
    endgenerate

    logic w_fall;
    logic w_frame_start;

    i2s_tx_bclk_gen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_bclk        (o_bclk),
        .o_lrclk       (o_lrclk),
        .o_fall        (w_fall),
        .o_frame_start (w_frame_start)
    );

    logic [SAMPLE_W-1:0] r_hold_left;
    logic [SAMPLE_W-1:0] r_hold_right;
    logic                r_hold_full;
    logic                r_ready;
    logic [FRAME_W-1:0]  r_shift;
    logic                r_sdata;
    logic                r_underrun;

    logic                w_xfer;
    logic                w_hold_full_nxt;
    logic [FRAME_W-1:0]  w_hold_frame;
    logic [FRAME_W-1:0]  w_load_frame;
    logic [FRAME_W-1:0]  w_shift_nxt;
    logic                w_sdata_nxt;
    logic                w_underrun_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_full <= 1'b0;
            r_ready     <= 1'b0;
            r_shift     <= '0;
            r_sdata     <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_hold_full <= w_hold_full_nxt;
            r_ready     <= !w_hold_full_nxt;
            r_shift     <= w_shift_nxt;
            r_sdata     <= w_sdata_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

    // Data registers need no reset: they are only observed while r_hold_full is set.
    always_ff @(posedge i_clk) begin
        if (w_xfer) begin
            r_hold_left  <= i_left;
            r_hold_right <= i_right;
        end
    end

    always_comb begin
        w_xfer = i_valid && r_ready;

        // A transfer can only happen while the buffer is empty, so it never races
        // a buffer-draining load; it may coincide with an empty (underrun) load.
        w_hold_full_nxt = r_hold_full;
        if (w_xfer) begin
            w_hold_full_nxt = 1'b1;
        end else if (w_frame_start) begin
            w_hold_full_nxt = 1'b0;
        end

        // Frame image: left slot then right slot, each sample MSB-aligned and zero padded.
        w_hold_frame = (FRAME_W'(r_hold_left) << (FRAME_W - SAMPLE_W))
                     | (FRAME_W'(r_hold_right) << PAD_W);
        w_load_frame = r_hold_full ? w_hold_frame : '0;

        w_shift_nxt    = r_shift;
        w_sdata_nxt    = r_sdata;
        w_underrun_nxt = 1'b0;
        if (w_frame_start) begin
            w_sdata_nxt    = w_load_frame[FRAME_W-1];
            w_shift_nxt    = w_load_frame << 1;
            w_underrun_nxt = !r_hold_full;
        end else if (w_fall) begin
            w_sdata_nxt = r_shift[FRAME_W-1];
            w_shift_nxt = r_shift << 1;
        end
    end

    assign o_ready    = r_ready;
    assign o_sdata    = r_sdata;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// ----------------------------------------------------------------------------
// tb_i2s_tx
// Directed bench for i2s_tx at default geometry (24-bit samples, 32-bit slots,
// BCLK_DIV = 8). Inputs change on clk falling edges; a receiver model samples
// outputs 1 time unit after each rising edge and captures sdata on bclk rises.
// ----------------------------------------------------------------------------
module tb_i2s_tx;

    localparam int BCLK_DIV = 8;
    localparam int FRAME_CLKS = int'(i2s_pkg::frame_clks(32, 8));

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] left = '0;
    logic [23:0] right = '0;
    logic        valid = 1'b0;
    logic        ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    always #5 clk = ~clk;

    i2s_tx u_dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_left     (left),
        .i_right    (right),
        .i_valid    (valid),
        .o_ready    (ready),
        .o_bclk     (bclk),
        .o_lrclk    (lrclk),
        .o_sdata    (sdata),
        .o_underrun (underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Receiver / timing monitor
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          rise_cnt = 0;
    logic [63:0] acc = '0;
    logic [63:0] frames[$];
    int          first_rise = -1;
    int          first_fall = -1;
    int          last_bclk_edge = 0;
    int          bclk_bad = 0;
    int          lr_bad = 0;
    int          lr_rise_t = -1;
    int          lr_period = -1;
    int          lr_high = -1;
    int          und_cnt = 0;
    int          und_cyc = -1;
    logic        prev_bclk = 1'b0;
    logic        prev_lr = 1'b0;

    always @(posedge clk) begin
        logic rst_e;
        logic bclk_fell;
        int   bits;
        rst_e = reset;
        #1;
        if (rst_e) begin
            cyc            = 0;
            rise_cnt       = 0;
            acc            = '0;
            first_rise     = -1;
            first_fall     = -1;
            last_bclk_edge = 0;
            lr_rise_t      = -1;
            und_cnt        = 0;
            und_cyc        = -1;
            prev_bclk      = 1'b0;
            prev_lr        = 1'b0;
        end else begin
            cyc++;
            if (underrun) begin
                und_cnt++;
                und_cyc = cyc;
            end
            bclk_fell = (bclk != prev_bclk) && !bclk;
            if (bclk != prev_bclk) begin
                if (cyc - last_bclk_edge != BCLK_DIV) bclk_bad++;
                last_bclk_edge = cyc;
                if (bclk) begin
                    if (first_rise < 0) first_rise = cyc;
                    // The first rise after reset precedes the first frame bit.
                    if (rise_cnt > 0) begin
                        acc = {acc[62:0], sdata};
                        if (rise_cnt % 64 == 0) frames.push_back(acc);
                    end
                    rise_cnt++;
                end else if (first_fall < 0) begin
                    first_fall = cyc;
                end
            end
            if (lrclk != prev_lr) begin
                if (!bclk_fell) lr_bad++;
                bits = (rise_cnt > 0) ? (rise_cnt - 1) % 64 : -1;
                if (lrclk) begin
                    if (bits != 31) lr_bad++;
                    if (lr_rise_t >= 0) lr_period = cyc - lr_rise_t;
                    lr_rise_t = cyc;
                end else begin
                    if (bits != 63) lr_bad++;
                    if (lr_rise_t >= 0) lr_high = cyc - lr_rise_t;
                end
            end
            prev_bclk = bclk;
            prev_lr   = lrclk;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a clk falling edge)
    // ------------------------------------------------------------------
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        check_val("reset_outputs", {59'd0, bclk, lrclk, sdata, underrun, ready}, 64'd0);
        reset = 1'b0;
    endtask

    // Leaves valid asserted; returns the clk edge number of the transfer.
    task automatic send_pair(input logic [23:0] l, input logic [23:0] r, output int acc_cyc);
        left    = l;
        right   = r;
        valid   = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            if (ready === 1'b1) begin
                @(negedge clk);
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_cyc(input int t);
        for (int i = 0; i < 8 * FRAME_CLKS && cyc < t; i++) @(negedge clk);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 4 * FRAME_CLKS && frames.size() < n; i++) @(negedge clk);
        check_val("frames_received", 64'(frames.size() >= n), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [63:0] exp);
        logic [63:0] got;
        got = (frames.size() > idx) ? frames[idx] : 'x;
        check_val(tag, got, exp);
    endtask

    initial begin
        #(200 * FRAME_CLKS * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;

        // ---- Scenario 1: single pair, then underrun ----
        do_reset(2);
        frames.delete();
        send_pair(24'hA5A5A5, 24'h5A5A5A, a);
        valid = 1'b0;
        check_val("s1_accept_cyc", 64'(a), 64'd2);
        check_val("s1_ready_after_xfer", 64'(ready), 64'd0);
        wait_cyc(17);
        check_val("s1_ready_after_load", 64'(ready), 64'd1);
        check_val("s1_first_rise", 64'(first_rise), 64'd8);
        check_val("s1_first_fall", 64'(first_fall), 64'd16);
        check_val("s1_no_underrun", 64'(und_cnt), 64'd0);
        wait_frames(1);
        check_frame("s1_frame0", 0, 64'hA5A5A500_5A5A5A00);
        wait_cyc(1045);
        check_val("s1_underrun_cyc", 64'(und_cyc), 64'd1040);
        check_val("s1_underrun_width", 64'(und_cnt), 64'd1);
        wait_frames(2);
        check_frame("s1_frame1_zero", 1, 64'd0);

        // ---- Scenario 2: back-to-back with valid held, free-running timing ----
        do_reset(2);
        frames.delete();
        send_pair(24'h123456, 24'h789ABC, a);
        check_val("s2_accept1", 64'(a), 64'd2);
        send_pair(24'hFEDCBA, 24'h012345, a);
        check_val("s2_accept2", 64'(a), 64'd17);
        send_pair(24'hC3C3C3, 24'h3C3C3C, a);
        check_val("s2_accept3", 64'(a), 64'd1041);
        valid = 1'b0;
        wait_cyc(3000);
        check_val("s2_no_underrun", 64'(und_cnt), 64'd0);
        wait_frames(3);
        check_frame("s2_frame0", 0, 64'h12345600_789ABC00);
        check_frame("s2_frame1", 1, 64'hFEDCBA00_01234500);
        check_frame("s2_frame2", 2, 64'hC3C3C300_3C3C3C00);
        check_val("s2_lrclk_period", 64'(lr_period), 64'd1024);
        check_val("s2_lrclk_high", 64'(lr_high), 64'd512);
        check_val("s2_bclk_half_period_errs", 64'(bclk_bad), 64'd0);
        check_val("s2_lrclk_align_errs", 64'(lr_bad), 64'd0);

        // ---- Scenario 3: reset mid-frame, then extreme values ----
        do_reset(2);
        frames.delete();
        send_pair(24'h0F0F0F, 24'hF0F0F0, a);
        send_pair(24'hABCDEF, 24'hFEDCBA, a);
        check_val("s3_held_accept", 64'(a), 64'd17);
        valid = 1'b0;
        wait_cyc(179);
        do_reset(1);  // reset sampled at edge 180, position 10 of frame 0
        frames.delete();
        send_pair(24'h800000, 24'h7FFFFF, a);
        valid = 1'b0;
        check_val("s3_accept", 64'(a), 64'd2);
        wait_cyc(17);
        check_val("s3_first_rise", 64'(first_rise), 64'd8);
        check_val("s3_first_fall", 64'(first_fall), 64'd16);
        wait_frames(1);
        check_frame("s3_frame_extremes", 0, 64'h80000000_7FFFFF00);
        check_val("s3_no_underrun", 64'(und_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter: accepts parallel stereo PCM samples over a valid/ready handshake and serialises them as bclk, lrclk and sdata in Philips I2S format.
- Counterpart of the visualizer's I2S capture path. Drives an external DAC, and serves as a synthesizable microphone model that feeds the FFT front end in loop-back benches.

Parameters:
- SAMPLE_W, 24, sample width in bits, two's complement; must satisfy SAMPLE_W <= SLOT_W (elaboration-time check).
- SLOT_W, 32, bclk periods per channel slot.
- BCLK_DIV, 8, clk cycles per bclk half-period; must be >= 2. Defaults at 50 MHz give a 1024-clk frame, about 48.8 kHz.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_left  in  SAMPLE_W  left sample
- in_right  in  SAMPLE_W  right sample
- in_valid  in  1  sample pair valid
- in_ready  out  1  holding buffer empty
- bclk  out  1  bit clock
- lrclk  out  1  word select (0 = left, 1 = right)
- sdata  out  1  serial data, MSB first
- underrun  out  1  one-cycle pulse when a frame starts with no sample

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- All outputs are registered.
- Reset values: bclk=0, lrclk=0, sdata=0, underrun=0, in_ready=0 while reset is asserted. Internal reset values: div_cnt=0, frame position p=2*SLOT_W-1, holding buffer empty, shift register zero.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1; at BCLK_DIV-1 it wraps and bclk toggles.
  - A 1->0 toggle is a "fall event"; p advances on fall events only, wrapping 2*SLOT_W-1 -> 0.
- Position decode, updated on the same clk edge as the fall event:
  - lrclk=1 for p in [SLOT_W-1, 2*SLOT_W-2], else 0. lrclk therefore leads each slot's MSB by one bclk.
  - sdata carries the left slot for p 0..SLOT_W-1 and the right slot for p SLOT_W..2*SLOT_W-1.
  - Within a slot: sample bits MSB first, then SLOT_W-SAMPLE_W zero pad bits.
  - sdata changes only on fall events; the receiver samples on bclk rising.
- First-frame timing: after reset release, the first rise is at clk cycle BCLK_DIV and the first fall (p=0) at cycle 2*BCLK_DIV.
- Handshake:
  - One-deep holding buffer; in_ready = !hold_full.
  - Transfer occurs on a clk edge with in_valid && in_ready.
  - in_valid may be held; data must be stable while in_valid=1 and in_ready=0.
- Frame load, on the fall event that sets p=0:
  - If hold_full: copy the buffer to the shift register, clear hold_full; in_ready rises the next cycle.
  - If empty: load zeros and pulse underrun for exactly that cycle.
  - A transfer in the same cycle as an empty-buffer load fills the buffer for the next frame only. The current frame stays zero and underrun still fires.
- Reset asserted mid-frame: all state returns to reset values on the next edge and the held sample is discarded. Timing then restarts exactly as after power-on reset.
- No sample is ever dropped or duplicated outside reset.

Decomposition:
- Package i2s_pkg holds:
  - LRCLK_LEFT / LRCLK_RIGHT constants
  - default SAMPLE_W, SLOT_W, BCLK_DIV
  - frame-position typedef of width $clog2(2*SLOT_W)
  - a function returning frame length in clk cycles, for benches
- Sub-module i2s_bclk_gen: div_cnt, bclk, fall-event strobe, p counter and lrclk decode.
- i2s_tx keeps the handshake buffer, shift register, sdata and underrun.

Test Plan:
- Reset, then present left=24'hA5A5A5, right=24'h5A5A5A before cycle 2*BCLK_DIV. A bench I2S receiver sampling on bclk rising captures exactly these values, with pad bits 24..31 all zero, in_ready=1 again after the load.
- Free-running timing check: bclk period 16 clk; lrclk period 1024 clk, 50% duty. Every lrclk edge coincides with a bclk fall, one bclk before the slot MSB.
- Back-to-back: in_valid held high with 3 distinct pairs. Pair 1 is accepted at once. Pair 2 waits with in_ready=0 and is accepted the cycle after frame-1 load. The three frames carry pairs 1, 2, 3 in order, with no underrun.
- Underrun: supply one pair, then none. Frame 2 start pulses underrun for exactly 1 clk; sdata=0 for all 64 bits.
- Reset asserted for 1 clk at p=10 of a frame. The next cycle shows bclk=lrclk=sdata=0 and in_ready=0. After release, a newly supplied pair is transmitted with timing identical to the first scenario.
- Extremes: left=24'h800000, right=24'h7FFFFF. Left slot is 1 followed by 31 zeros; right slot is 0, 23 ones, 8 zeros.
